key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have parameter KEY_LENGTH, default 128, cipher key and round key width in bits.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, number of expanded round keys after the cipher key.
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request to expand key_in.
REQ-006 SHALL have port key_in, input, KEY_LENGTH bits, cipher key; w0 in [127:96], w3 in [31:0].
REQ-007 SHALL have port rk_addr, input, 4 bits, round key read index, 0..NUM_ROUNDS.
REQ-008 SHALL have port busy, output, 1 bit, expansion in progress.
REQ-009 SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-010 SHALL have port keys_valid, output, 1 bit, full schedule stored and readable.
REQ-011 SHALL have port rk_data, output, KEY_LENGTH bits, round key selected by rk_addr.
REQ-012 SHALL have port zeroize, input, 1 bit, present only when KEY_SCHED_ZEROIZE_EN is defined.

Function
REQ-013 SHALL implement states IDLE and EXPAND, plus a 4-bit round counter rnd and a key store rk[0..NUM_ROUNDS].
REQ-014 SHALL, in IDLE with start=1 at edge E0: write key_in to rk[0], set rnd=1, clear keys_valid, enter EXPAND.
REQ-015 SHALL, in each EXPAND cycle, compute one AES-128 expansion round combinationally from rk[rnd-1] with round index rnd (RotWord, SubWord, Rcon[rnd], chained XOR of w0..w3), write it to rk[rnd] and increment rnd.
REQ-016 SHALL write rk[r] at edge E_r, so rk[NUM_ROUNDS] is written at edge E10; total latency is 10 cycles from the start edge.
REQ-017 SHALL return to IDLE at E10, set keys_valid=1, and drive done=1 for exactly the cycle after E10.
REQ-018 SHALL drive busy=1 in every cycle between E0 and E10 and busy=0 in IDLE.
REQ-019 SHALL ignore start while in EXPAND; key_in is sampled only at E0 and may change afterwards.
REQ-020 SHALL accept start in the cycle done is high; this restarts expansion and clears keys_valid at that edge.
REQ-021 SHALL drive rk_data = rk[rk_addr] combinationally, with zero latency.
REQ-022 SHALL drive rk_data = 0 when rk_addr > NUM_ROUNDS or keys_valid=0.
REQ-023 SHALL use the Rcon sequence 01,02,04,08,10,20,40,80,1B,36 for rnd 1..10.

Reset
REQ-024 SHALL, while rst=1 and regardless of clk, force IDLE, rnd=0, all rk entries=0, busy=0, done=0, keys_valid=0 and rk_data=0.
REQ-025 SHALL, when rst is asserted mid-EXPAND, abandon the partial schedule; the first edge after release with start=1 begins a fresh expansion.

Configuration
REQ-026 SHALL, with KEY_SCHED_ZEROIZE_EN defined, on zeroize=1 at a clock edge: clear all rk entries and keys_valid, abort EXPAND to IDLE without a done pulse, and take priority over a simultaneous start.
REQ-027 SHALL, without KEY_SCHED_ZEROIZE_EN, omit the zeroize port; key material is then cleared only by rst.

Verification
REQ-028 SHALL cover: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done exactly 10 cycles later; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 SHALL cover: key_in=000102030405060708090a0b0c0d0e0f -> rk[10]=13111d7fe3944a17f307a78b4d2b30c5; rk_addr=11..15 -> rk_data=0.
REQ-030 SHALL cover: start reasserted with a different key_in at cycle 5 of an expansion -> ignored; results match the first key and done is still at cycle 10.
REQ-031 SHALL cover: rst pulsed at cycle 4 of an expansion -> busy=0, keys_valid=0 and rk_data=0 immediately; a new start then completes normally.
REQ-032 SHALL cover: start asserted during the done cycle -> keys_valid drops, busy=1 and a second done appears 10 cycles later.
REQ-033 SHALL cover, with KEY_SCHED_ZEROIZE_EN: zeroize together with start at cycle 6 -> IDLE, all keys 0, no done pulse, start not accepted.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : key_schedule_ctrl
//  Description : Iterative AES-128 key expansion controller. A start request
//                captures the cipher key into round-key slot 0. The module
//                then produces one expanded round key per clock and stores
//                the full schedule. Any stored round key can be read back
//                combinationally by index once the schedule is complete.
//
//  Parameters  : KEY_LENGTH - cipher/round key width in bits (AES-128: 128)
//                NUM_ROUNDS - expanded round keys after the cipher key (10)
//
//  Ports       : clk        - clock, all state updates on its rising edge
//                rst        - asynchronous active-high reset
//                start      - request to expand key_in (ignored while busy)
//                zeroize    - wipe key store / abort expansion (optional)
//                key_in     - cipher key, w0 in [127:96] .. w3 in [31:0]
//                rk_addr    - round key read index, 0..NUM_ROUNDS
//                busy       - expansion in progress
//                done       - one-cycle pulse after the last round key write
//                keys_valid - full schedule stored and readable
//                rk_data    - round key selected by rk_addr (0 if invalid)
//
//  Build option: define KEY_SCHED_ZEROIZE_EN to add the zeroize port.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_ctrl #(
    parameter int KEY_LENGTH = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef KEY_SCHED_ZEROIZE_EN
    input  logic                  zeroize,
`endif
    input  logic [KEY_LENGTH-1:0] key_in,
    input  logic [3:0]            rk_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  keys_valid,
    output logic [KEY_LENGTH-1:0] rk_data
);

    // ------------------------------------------------------------------------
    // AES forward S-box, entry 0 in the most significant byte.
    // ------------------------------------------------------------------------
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] c_LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    // Entry b lives at bit 8*(255-b)+7 = {~b, 3'b111}, which keeps the
    // part-select index at its natural 11-bit width.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [3:0]            r_rnd;
    logic [KEY_LENGTH-1:0] r_rk [0:NUM_ROUNDS];

    logic                  w_zeroize;
    logic [KEY_LENGTH-1:0] w_prev;
    logic [KEY_LENGTH-1:0] w_next;

`ifdef KEY_SCHED_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    // Previous round key rk[rnd-1]; rnd is 1..NUM_ROUNDS while expanding.
    always_comb begin
        w_prev = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (r_rnd == 4'(i + 1)) begin
                w_prev = r_rk[i];
            end
        end
    end

    // One AES-128 expansion round: the first new word takes
    // SubWord(RotWord(w3)) ^ Rcon, the remaining three chain off it.
    always_comb begin
        logic [31:0] w_t;
        logic [31:0] w_w4;
        logic [31:0] w_w5;
        logic [31:0] w_w6;
        logic [31:0] w_w7;
        w_t  = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(r_rnd), 24'h000000};
        w_w4 = w_prev[KEY_LENGTH-1 -: 32] ^ w_t;
        w_w5 = w_prev[KEY_LENGTH-33 -: 32] ^ w_w4;
        w_w6 = w_prev[KEY_LENGTH-65 -: 32] ^ w_w5;
        w_w7 = w_prev[31:0] ^ w_w6;
        w_next = {w_w4, w_w5, w_w6, w_w7};
    end

    // ------------------------------------------------------------------------
    // Controller and key store
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rnd      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (w_zeroize) begin
                // Wipe wins over start and silently abandons any expansion.
                r_state    <= S_IDLE;
                r_rnd      <= 4'd0;
                busy       <= 1'b0;
                keys_valid <= 1'b0;
                for (int i = 0; i <= NUM_ROUNDS; i++) begin
                    r_rk[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_rk[0]    <= key_in;
                            r_rnd      <= 4'd1;
                            keys_valid <= 1'b0;
                            busy       <= 1'b1;
                            r_state    <= S_EXPAND;
                        end
                    end
                    S_EXPAND: begin
                        for (int i = 1; i <= NUM_ROUNDS; i++) begin
                            if (r_rnd == 4'(i)) begin
                                r_rk[i] <= w_next;
                            end
                        end
                        r_rnd <= r_rnd + 4'd1;
                        if (r_rnd == c_LAST_RND) begin
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                            keys_valid <= 1'b1;
                            done       <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Zero-latency read port; out-of-range or incomplete schedules read 0.
    // ------------------------------------------------------------------------
    always_comb begin
        rk_data = '0;
        if (keys_valid) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                if (rk_addr == 4'(i)) begin
                    rk_data = r_rk[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_key_schedule_ctrl
//  Description : Self-checking bench for key_schedule_ctrl. Expected round
//                keys come from a word-array AES-128 key expansion whose
//                S-box is derived from GF(2^8) inversion plus the affine map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rk_addr;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [127:0] rk_data;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];

    always #5 clk = ~clk;

    key_schedule_ctrl #(
        .KEY_LENGTH(128),
        .NUM_ROUNDS(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef KEY_SCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .rk_addr    (rk_addr),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_data    (rk_data)
    );

    // ---------------------------------------------------------------- model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            sbox_m[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                        ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // -------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an expansion, check the first busy cycle, then wait for done.
    task automatic expand(input logic [127:0] key, output int lat);
        key_in = key;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        check("busy_after_start", 128'(busy), 128'd1);
        check("kv_during_expand", 128'(keys_valid), 128'd0);
        check("rk_data_during_expand", rk_data, 128'd0);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_all(input string tag, input logic [127:0] key);
        model(key);
        for (int a = 0; a < 16; a++) begin
            rk_addr = 4'(a);
            #1;
            check($sformatf("%s_rk%0d", tag, a), rk_data, (a <= 10) ? exp_rk[a] : 128'd0);
        end
        rk_addr = 4'd0;
    endtask

    task automatic after_done(input string tag, input int lat);
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_busy_low"}, 128'(busy), 128'd0);
        check({tag, "_kv_high"}, 128'(keys_valid), 128'd1);
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        int           lat;
        logic [127:0] k1;
        logic [127:0] k2;

        rst     = 1'b1;
        start   = 1'b0;
        key_in  = '0;
        rk_addr = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        build_sbox();

        // Reset state
        repeat (3) step();
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_kv", 128'(keys_valid), 128'd0);
        check("reset_rk_data", rk_data, 128'd0);
        rst = 1'b0;
        step();

        // FIPS-197 key
        k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand(k1, lat);
        after_done("fips", lat);
        rk_addr = 4'd1;
        #1 check("fips_kat_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rk_addr = 4'd10;
        #1 check("fips_kat_rk10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        step();
        check("done_one_cycle", 128'(done), 128'd0);
        check_all("fips", k1);

        // Sequential key, including rk_addr 11..15
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        step();
        expand(k1, lat);
        after_done("seq", lat);
        rk_addr = 4'd10;
        #1 check("seq_kat_rk10", rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check_all("seq", k1);

        // Restart attempt with another key mid-expansion is ignored
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k1;
        step();
        key_in = k1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = k2;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            start = (n == 5);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        after_done("ignore_start", lat);
        check_all("ignore_start", k1);

        // Reset mid-expansion
        step();
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_kv", 128'(keys_valid), 128'd0);
        check("midrst_rk_data", rk_data, 128'd0);
        step();
        rst = 1'b0;
        step();
        k1 = {$urandom, $urandom, $urandom, $urandom};
        expand(k1, lat);
        after_done("post_rst", lat);
        check_all("post_rst", k1);

        // Start during the done cycle
        step();
        k1 = {$urandom, $urandom, $urandom, $urandom};
        expand(k1, lat);
        after_done("back2back_first", lat);
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key_in = k2;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check("b2b_kv_drop", 128'(keys_valid), 128'd0);
        check("b2b_busy", 128'(busy), 128'd1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (done) begin
                lat = n;
                break;
            end
        end
        after_done("back2back_second", lat);
        check_all("b2b", k2);

        // Random keys
        for (int r = 0; r < 4; r++) begin
            step();
            k1 = {$urandom, $urandom, $urandom, $urandom};
            expand(k1, lat);
            after_done($sformatf("rand%0d", r), lat);
            check_all($sformatf("rand%0d", r), k1);
        end

`ifdef KEY_SCHED_ZEROIZE_EN
        // Zeroize with simultaneous start at cycle 6
        step();
        key_in = {$urandom, $urandom, $urandom, $urandom};
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (5) step();
        zeroize = 1'b1;
        start   = 1'b1;
        key_in  = {$urandom, $urandom, $urandom, $urandom};
        step();
        zeroize = 1'b0;
        start   = 1'b0;
        check("zero_busy", 128'(busy), 128'd0);
        check("zero_kv", 128'(keys_valid), 128'd0);
        check("zero_rk_data", rk_data, 128'd0);
        lat = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) lat++;
            step();
        end
        check("zero_no_done", 128'(lat), 128'd0);
        check("zero_still_idle", 128'(busy), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
